// File: rtl/galaksija_tape_rec.sv
// Cassette SAVE decoder: turns the CPU tape pulse stream into bytes in the tape buffer.
// Optional running byte checksum on rec_sum is built when TAPE_REC_SUM_EN is defined.
module galaksija_tape_rec #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned HALF_MIN = 2300,
    parameter int unsigned HALF_MAX = 6900,
    parameter int unsigned TIMEOUT  = 40000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              tape_in,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_data,
    output logic              buf_we,
    output logic              rec_active,
    output logic              rec_done,
    output logic [ADDR_W:0]   rec_len,
    output logic              overflow,
    output logic [7:0]        rec_sum
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(HALF_MIN);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HALF_MAX);
    localparam logic [CNT_W-1:0] CNT_TMO  = CNT_W'(TIMEOUT);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(2 ** ADDR_W);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'((2 ** ADDR_W) - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_DATA = 2'd1;
    localparam logic [1:0] ST_WAIT_CLK  = 2'd2;
    localparam logic [1:0] ST_END       = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             prev_tape;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shreg;
    logic [2:0]       bitcnt;

    logic             pulse_c;
    logic             start_c;
    logic             cnt_clr_c;
    logic             bit_commit_c;
    logic             bit_val_c;
    logic [7:0]       byte_val_c;
    logic             byte_store_c;

    assign pulse_c      = prev_tape & ~tape_in;
    assign byte_val_c   = {bit_val_c, shreg[7:1]};
    assign byte_store_c = bit_commit_c && (bitcnt == 3'd7) && (rec_len != LEN_FULL);

    // Next state and per-cycle decode actions; a pulse always beats the timeout.
    always_comb begin
        state_nxt    = state;
        start_c      = 1'b0;
        cnt_clr_c    = 1'b0;
        bit_commit_c = 1'b0;
        bit_val_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pulse_c && arm) begin
                    start_c   = 1'b1;
                    cnt_clr_c = 1'b1;
                    state_nxt = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (pulse_c && (cnt >= CNT_MIN)) begin
                    cnt_clr_c    = 1'b1;
                    bit_commit_c = 1'b1;
                    if (cnt < CNT_MAX) begin
                        bit_val_c = 1'b1;
                        state_nxt = ST_WAIT_CLK;
                    end
                end else if (cnt == CNT_TMO) begin
                    bit_commit_c = 1'b1;
                    state_nxt    = ST_END;
                end
            end
            ST_WAIT_CLK: begin
                if (pulse_c && (cnt >= CNT_MIN)) begin
                    cnt_clr_c = 1'b1;
                    state_nxt = ST_WAIT_DATA;
                end else if (cnt == CNT_TMO) begin
                    state_nxt = ST_END;
                end
            end
            ST_END: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Disarming ends the record, but a bit decoded this cycle is still kept.
        if (!arm && ((state == ST_WAIT_DATA) || (state == ST_WAIT_CLK))) begin
            state_nxt = ST_END;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            prev_tape <= 1'b1;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            prev_tape <= tape_in;
            if (cnt_clr_c) begin
                cnt <= '0;
            end else if (cnt != CNT_TMO) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Bit assembly, buffer write strobe and record bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= 8'h00;
            bitcnt     <= 3'd0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= 8'h00;
            rec_len    <= '0;
            overflow   <= 1'b0;
            rec_active <= 1'b0;
            rec_done   <= 1'b0;
        end else begin
            buf_we   <= 1'b0;
            rec_done <= 1'b0;
            if (start_c) begin
                shreg      <= 8'h00;
                bitcnt     <= 3'd0;
                buf_addr   <= '0;
                rec_len    <= '0;
                overflow   <= 1'b0;
                rec_active <= 1'b1;
            end else begin
                if (bit_commit_c) begin
                    shreg  <= byte_val_c;
                    bitcnt <= bitcnt + 3'd1;
                end
                if (byte_store_c) begin
                    buf_we   <= 1'b1;
                    buf_data <= byte_val_c;
                    buf_addr <= rec_len[ADDR_W-1:0];
                end
                // Length follows the strobe by one cycle; reaching capacity flags overflow.
                if (buf_we) begin
                    rec_len <= rec_len + LEN_W'(1);
                    if (rec_len == LEN_LAST) begin
                        overflow <= 1'b1;
                    end
                end
                if (state == ST_END) begin
                    bitcnt <= 3'd0;
                end
                if ((state_nxt == ST_END) && (state != ST_END)) begin
                    rec_done   <= 1'b1;
                    rec_active <= 1'b0;
                end
            end
        end
    end

`ifdef TAPE_REC_SUM_EN
    // Modulo-256 sum of every byte actually written to the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_sum <= 8'h00;
        end else if (start_c) begin
            rec_sum <= 8'h00;
        end else if (buf_we) begin
            rec_sum <= rec_sum + buf_data;
        end
    end
`else
    assign rec_sum = 8'h00;
`endif

endmodule

// File: tb/tb_galaksija_tape_rec.sv
// Bench for galaksija_tape_rec: directed and randomized pulse streams against an interval-based decode model.
module tb_galaksija_tape_rec;

    localparam int AW   = 2;
    localparam int HMIN = 23;
    localparam int HMAX = 69;
    localparam int TMO  = 400;
    localparam int CW   = 10;
    localparam int CAP  = 4;

    logic          clk;
    logic          reset;
    logic          arm;
    logic          tape_in;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic          buf_we;
    logic          rec_active;
    logic          rec_done;
    logic [AW:0]   rec_len;
    logic          overflow;
    logic [7:0]    rec_sum;

    galaksija_tape_rec #(
        .ADDR_W(AW), .HALF_MIN(HMIN), .HALF_MAX(HMAX), .TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .tape_in(tape_in),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
        .rec_active(rec_active), .rec_done(rec_done), .rec_len(rec_len),
        .overflow(overflow), .rec_sum(rec_sum)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed writes and record ends, sampled mid-cycle.
    int wr_cyc[$];
    int wr_addr[$];
    int wr_data[$];
    int done_cyc[$];
    int done_act[$];

    always @(negedge clk) begin
        if (buf_we === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(buf_addr));
            wr_data.push_back(int'(buf_data));
        end
        if (rec_done === 1'b1) begin
            done_cyc.push_back(cyc);
            done_act.push_back(rec_active ? 1 : 0);
        end
    end

    // Stimulus: relative pulse times, converted to absolute cycles on playback.
    int rel[$];
    int pt[$];
    int pos = 0;

    // Reference expectations.
    int         exp_wr_cyc[$];
    int         exp_wr_addr[$];
    int         exp_wr_data[$];
    int         exp_done_n;
    int         exp_done_cyc;
    int         m_bits;
    logic [7:0] m_sh;
    int         m_nwr;
    int         m_sum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_bit(input bit b, input int dclk, input int ddat, input int glitch);
        rel.push_back(pos);
        if (glitch > 0) rel.push_back(pos + glitch);
        if (b) rel.push_back(pos + ddat);
        pos += dclk;
    endtask

    // kind 0: nominal timing; kind 1: random timing with occasional glitches.
    task automatic add_byte(input logic [7:0] v, input int kind);
        int ddat;
        int dclk;
        int gl;
        for (int i = 0; i < 8; i++) begin
            if (kind == 0) begin
                add_bit(v[i], 92, 46, 0);
            end else begin
                gl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 15)) : 0;
                if (v[i]) begin
                    ddat = int'($urandom_range(24, 69));
                    dclk = ddat + int'($urandom_range(24, 120));
                end else begin
                    dclk = int'($urandom_range(70, 200));
                    ddat = 0;
                end
                add_bit(v[i], dclk, ddat, gl);
            end
        end
    endtask

    task automatic commit(input logic b, input int t);
        m_sh = {b, m_sh[7:1]};
        m_bits++;
        if (m_bits == 8) begin
            m_bits = 0;
            if (m_nwr < CAP) begin
                exp_wr_cyc.push_back(t + 1);
                exp_wr_addr.push_back(m_nwr);
                exp_wr_data.push_back(int'(m_sh));
                m_nwr++;
                m_sum = (m_sum + int'(m_sh)) % 256;
            end
        end
    endtask

    // Decode by pulse intervals: interval-1 is the count seen by the receiver.
    task automatic model_run(input int mode, input int ev);
        int last;
        bit wclk;
        int c;
        int tend;
        exp_wr_cyc.delete();
        exp_wr_addr.delete();
        exp_wr_data.delete();
        m_bits = 0; m_sh = 8'h00; m_nwr = 0; m_sum = 0;
        exp_done_n = 0; exp_done_cyc = 0;
        if (mode == 2) return;
        last = pt[0];
        wclk = 1'b0;
        for (int i = 1; i < pt.size(); i++) begin
            if (mode == 1 && pt[i] > ev) break;
            c = pt[i] - last - 1;
            if (c < HMIN) continue;
            if (wclk) begin
                wclk = 1'b0;
            end else if (c < HMAX) begin
                commit(1'b1, pt[i]);
                wclk = 1'b1;
            end else begin
                commit(1'b0, pt[i]);
            end
            last = pt[i];
        end
        if (mode == 1) begin
            exp_done_cyc = ev + 1;
        end else begin
            tend = last + TMO + 1;
            if (!wclk) commit(1'b0, tend);
            exp_done_cyc = tend + 1;
        end
        exp_done_n = 1;
    endtask

    // mode 0: end by silence; 1: drop arm off cycles after last pulse; 2: reset there.
    task automatic play(input int mode, input int off);
        int k;
        int endc;
        int ev;
        k = 0;
        pt.delete();
        @(posedge clk); #1;
        foreach (rel[i]) pt.push_back(cyc + 2 + rel[i]);
        ev   = pt[pt.size()-1] + off;
        endc = (mode == 0) ? pt[pt.size()-1] + TMO + 20 : ev + 12;
        model_run(mode, ev);
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        done_cyc.delete(); done_act.delete();
        while (cyc < endc) begin
            @(posedge clk); #1;
            while (k < pt.size() && pt[k] + 1 < cyc) k++;
            tape_in = (k < pt.size() && (cyc == pt[k] || cyc == pt[k] + 1)) ? 1'b0 : 1'b1;
            if (mode == 1 && cyc == ev) arm = 1'b0;
            if (mode == 2 && cyc == ev) reset = 1'b1;
            if (mode == 2 && cyc == ev + 2) reset = 1'b0;
        end
        tape_in = 1'b1;
        arm     = 1'b1;
        reset   = 1'b0;
        rel.delete();
        pos = 0;
    endtask

    task automatic check_record(input string tag);
        int n;
        int es;
        check({tag, ".nwr"}, wr_cyc.size(), exp_wr_cyc.size());
        n = (wr_cyc.size() < exp_wr_cyc.size()) ? wr_cyc.size() : exp_wr_cyc.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.wr%0d.cyc", tag, i), wr_cyc[i], exp_wr_cyc[i]);
            check($sformatf("%s.wr%0d.addr", tag, i), wr_addr[i], exp_wr_addr[i]);
            check($sformatf("%s.wr%0d.data", tag, i), wr_data[i], exp_wr_data[i]);
        end
        check({tag, ".ndone"}, done_cyc.size(), exp_done_n);
        if (done_cyc.size() == 1 && exp_done_n == 1) begin
            check({tag, ".done_cyc"}, done_cyc[0], exp_done_cyc);
            check({tag, ".done_active"}, done_act[0], 0);
        end
`ifdef TAPE_REC_SUM_EN
        es = m_sum;
`else
        es = 0;
`endif
        @(negedge clk);
        check({tag, ".rec_len"}, rec_len, m_nwr);
        check({tag, ".overflow"}, overflow, (m_nwr == CAP) ? 1 : 0);
        check({tag, ".rec_sum"}, rec_sum, es);
        check({tag, ".rec_active"}, rec_active, 0);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; tape_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.buf_we", buf_we, 0);
        check("rst.buf_addr", buf_addr, 0);
        check("rst.buf_data", buf_data, 0);
        check("rst.rec_active", rec_active, 0);
        check("rst.rec_done", rec_done, 0);
        check("rst.rec_len", rec_len, 0);
        check("rst.overflow", overflow, 0);
        check("rst.rec_sum", rec_sum, 0);
        @(posedge clk); #1;
        reset = 1'b0; arm = 1'b1;

        // Clock pulse plus one data pulse, then silence: partial bit only.
        rel.push_back(0); rel.push_back(46);
        play(0, 0);
        check_record("partial");

        add_byte(8'hA5, 0);
        play(0, 0);
        check_record("a5");

        add_byte(8'h01, 0); pos += 210;
        add_byte(8'hFF, 0); pos += 210;
        add_byte(8'h00, 0);
        play(0, 0);
        check_record("01ff00");

        add_byte(8'h10, 0); pos += 210;
        add_byte(8'h20, 0);
        play(0, 0);
        check_record("1020");

        // Glitch inside a 0-bit at count 500/9200 scale.
        add_bit(1'b0, 92, 0, 6);
        add_bit(1'b1, 92, 46, 0);
        for (int i = 0; i < 6; i++) add_bit(1'b0, 92, 0, (i == 2) ? 5 : 0);
        play(0, 0);
        check_record("glitch");

        // Interval edges: min data, max data, min clock, clock exactly at timeout.
        add_bit(1'b1, 100, 24, 0);
        add_bit(1'b1, 100, 69, 0);
        add_bit(1'b0, 70, 0, 0);
        add_bit(1'b0, 401, 0, 0);
        add_bit(1'b1, 100, 27, 23);
        add_bit(1'b0, 92, 0, 0);
        add_bit(1'b1, 92, 46, 0);
        add_bit(1'b1, 92, 46, 0);
        play(0, 0);
        check_record("edges");

        for (int i = 0; i < 6; i++) add_byte(8'($urandom_range(0, 255)), 1);
        play(0, 0);
        check_record("overflow");

        // Reset mid-byte after three committed bits.
        add_bit(1'b1, 92, 46, 0);
        add_bit(1'b0, 92, 0, 0);
        add_bit(1'b1, 92, 46, 0);
        play(2, 10);
        check_record("reset_mid");
        add_byte(8'h3C, 0);
        play(0, 0);
        check_record("after_reset");

        // Disarm mid-record, and disarm on the cycle that completes a byte.
        add_bit(1'b1, 92, 46, 0);
        add_bit(1'b0, 92, 0, 0);
        add_bit(1'b1, 92, 46, 0);
        play(1, 7);
        check_record("disarm");
        add_byte(8'hC3, 0);
        play(1, 0);
        check_record("disarm_commit");

        for (int r = 0; r < 6; r++) begin
            int nb;
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++) add_byte(8'($urandom_range(0, 255)), 1);
            play(0, 0);
            check_record($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
